// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU micro-sequencer: ALU function codes,
// instruction classes, flag bit positions, special register indices and
// the latched instruction record.
package alu_seq_ctrl_pkg;

    // ALU function codes as understood by alu_16b.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBC = 4'd3,
        ALU_AND = 4'd4,
        ALU_ORA = 4'd5,
        ALU_EOR = 4'd6,
        ALU_INC = 4'd7,
        ALU_DEC = 4'd8,
        ALU_SHL = 4'd9,
        ALU_SHR = 4'd10,
        ALU_ROL = 4'd11,
        ALU_ROR = 4'd12,
        ALU_PSA = 4'd13,
        ALU_PSB = 4'd14,
        ALU_LDZ = 4'd15
    } alu_fn_e;

    // Decoded instruction classes; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        CLS_RR     = 3'd0,
        CLS_RI     = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_RMW    = 3'd4,
        CLS_BRANCH = 3'd5
    } op_class_e;

    // Bit positions inside the ALU flags word.
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // Register bank indices with a fixed role.
    localparam logic [2:0] FLAGS_IDX = 3'd2;
    localparam logic [2:0] PC_IDX    = 3'd3;

    // Instruction fields captured at the accept handshake.
    typedef struct packed {
        logic [2:0]  cls;
        logic [3:0]  alu;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic        setf;
        logic        cmask;
        logic [1:0]  cbit;
        logic        cpol;
    } instr_t;

    // True for the six defined instruction classes.
    function automatic logic is_legal_class(input logic [2:0] cls);
        return (cls <= CLS_BRANCH);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_mem_wait_timer.sv
// Watchdog for memory wait states: counts wait cycles without an ack and
// flags expiry once the count reaches LIMIT. The count freezes at LIMIT.
module alu_seq_ctrl_mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired_o = (cnt_q == LIMIT_C);

    // Next count: clear has priority, otherwise step while enabled and not expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Micro-sequencer in front of alu_16b. Accepts one decoded instruction per
// handshake and then owns every ALU control input, stepping through the
// per-class state sequence. Memory classes use a req/ack port guarded by
// a wait-state watchdog.
//
// Handshake: an instruction transfers on a rising edge where instr_valid
// and instr_ready are both high; instr_ready is high only in IDLE, the
// fields are captured on that edge and the op_* inputs are ignored until
// the sequencer returns to IDLE. mem_req stays high until the cycle in
// which mem_ack is seen (or the watchdog aborts); mem_ack outside a wait
// state is ignored.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter logic [2:0]  SCRATCH_IDX = 3'd7,
    parameter int unsigned WAIT_LIMIT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  op_class,
    input  logic [3:0]  op_alu,
    input  logic [2:0]  op_ra,
    input  logic [2:0]  op_rb,
    input  logic [2:0]  op_rd,
    input  logic [15:0] op_imm,
    input  logic        op_setf,
    input  logic        op_cmask,
    input  logic [1:0]  op_cbit,
    input  logic        op_cpol,
    input  logic [15:0] alu_flags,
    input  logic [15:0] alu_mar,
    output logic [3:0]  alu_f,
    output logic [2:0]  a_idx,
    output logic [2:0]  b_idx,
    output logic [2:0]  d_idx,
    output logic        wr_reg,
    output logic        wr_flags,
    output logic        sel_inp,
    output logic        carry_mask,
    output logic [15:0] t16,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        done,
    output logic        err,
    output logic [3:0]  dbg_state_o
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_EXEC   = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_RWAIT  = 4'd3;
    localparam logic [3:0] S_WWAIT  = 4'd4;
    localparam logic [3:0] S_CLR    = 4'd5;
    localparam logic [3:0] S_MERGE  = 4'd6;
    localparam logic [3:0] S_SCLR   = 4'd7;
    localparam logic [3:0] S_SMERGE = 4'd8;
    localparam logic [3:0] S_ROP    = 4'd9;
    localparam logic [3:0] S_BR     = 4'd10;
    localparam logic [3:0] S_ERR    = 4'd11;

    logic [3:0]  state_q, state_d;
    instr_t      instr_q, instr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] rdata_q, rdata_d;

    logic        in_wait;
    logic        timer_clr;
    logic        timer_en;
    logic        expired;
    logic [3:0]  cond_flags;
    logic        br_taken;
    logic        unused_flags;

    // Only the four condition flags take part in branch decisions.
    assign cond_flags   = {alu_flags[FLAG_N], alu_flags[FLAG_Z],
                           alu_flags[FLAG_V], alu_flags[FLAG_C]};
    assign unused_flags = ^alu_flags[15:4];
    assign br_taken     = (cond_flags[instr_q.cbit] == instr_q.cpol);

    assign in_wait   = (state_q == S_RWAIT) || (state_q == S_WWAIT);
    // Each memory access (ADDR before the first, ROP before the RMW write-back) starts a fresh count.
    assign timer_clr = (state_q == S_ADDR) || (state_q == S_ROP);
    assign timer_en  = in_wait && !mem_ack;

    assign mem_addr    = mem_addr_q;
    assign dbg_state_o = state_q;

    alu_seq_ctrl_mem_wait_timer #(
        .LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (expired)
    );

    // Next-state, field capture, address and read-data capture.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        mem_addr_d = mem_addr_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d.cls   = op_class;
                    instr_d.alu   = op_alu;
                    instr_d.ra    = op_ra;
                    instr_d.rb    = op_rb;
                    instr_d.rd    = op_rd;
                    instr_d.imm   = op_imm;
                    instr_d.setf  = op_setf;
                    instr_d.cmask = op_cmask;
                    instr_d.cbit  = op_cbit;
                    instr_d.cpol  = op_cpol;
                    if (!is_legal_class(op_class)) begin
                        state_d = S_ERR;
                    end else if ((op_class == CLS_RR) || (op_class == CLS_RI)) begin
                        state_d = S_EXEC;
                    end else if (op_class == CLS_BRANCH) begin
                        state_d = S_BR;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_EXEC: state_d = S_IDLE;
            S_ADDR: begin
                // ALU computes a_val + t16; keep it so the bus address is stable.
                mem_addr_d = alu_mar;
                state_d    = (instr_q.cls == CLS_STORE) ? S_WWAIT : S_RWAIT;
            end
            S_RWAIT: begin
                if (expired) begin
                    state_d = S_IDLE;
                end else if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = (instr_q.cls == CLS_RMW) ? S_SCLR : S_CLR;
                end
            end
            S_WWAIT: begin
                if (expired || mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_CLR:    state_d = S_MERGE;
            S_MERGE:  state_d = S_IDLE;
            S_SCLR:   state_d = S_SMERGE;
            S_SMERGE: state_d = S_ROP;
            S_ROP:    state_d = S_WWAIT;
            S_BR:     state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore-style ALU/memory drive; only wait-state ack and branch condition are sampled live.
    always_comb begin
        instr_ready = 1'b0;
        alu_f       = 4'd0;
        a_idx       = 3'd0;
        b_idx       = 3'd0;
        d_idx       = 3'd0;
        wr_reg      = 1'b0;
        wr_flags    = 1'b0;
        sel_inp     = 1'b0;
        carry_mask  = 1'b0;
        t16         = 16'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                alu_f      = instr_q.alu;
                a_idx      = instr_q.ra;
                b_idx      = instr_q.rb;
                d_idx      = instr_q.rd;
                sel_inp    = (instr_q.cls == CLS_RR);
                t16        = instr_q.imm;
                carry_mask = instr_q.cmask;
                wr_reg     = 1'b1;
                wr_flags   = instr_q.setf;
                done       = 1'b1;
            end
            S_ADDR: begin
                a_idx = instr_q.ra;
                t16   = instr_q.imm;
            end
            S_RWAIT: begin
                if (expired) begin
                    err = 1'b1;
                end else begin
                    mem_req = 1'b1;
                end
            end
            S_WWAIT: begin
                // Memory takes its write data from the B bank at b_idx.
                b_idx = (instr_q.cls == CLS_RMW) ? SCRATCH_IDX : instr_q.rb;
                if (expired) begin
                    err = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    done    = mem_ack;
                end
            end
            S_CLR: begin
                alu_f  = ALU_LDZ;
                d_idx  = instr_q.rd;
                wr_reg = 1'b1;
            end
            S_MERGE: begin
                alu_f    = ALU_ORA;
                a_idx    = instr_q.rd;
                d_idx    = instr_q.rd;
                t16      = rdata_q;
                wr_reg   = 1'b1;
                wr_flags = instr_q.setf;
                done     = 1'b1;
            end
            S_SCLR: begin
                alu_f  = ALU_LDZ;
                d_idx  = SCRATCH_IDX;
                wr_reg = 1'b1;
            end
            S_SMERGE: begin
                alu_f  = ALU_ORA;
                a_idx  = SCRATCH_IDX;
                d_idx  = SCRATCH_IDX;
                t16    = rdata_q;
                wr_reg = 1'b1;
            end
            S_ROP: begin
                alu_f      = instr_q.alu;
                a_idx      = SCRATCH_IDX;
                b_idx      = SCRATCH_IDX;
                d_idx      = SCRATCH_IDX;
                sel_inp    = 1'b1;
                carry_mask = instr_q.cmask;
                wr_reg     = 1'b1;
                wr_flags   = instr_q.setf;
            end
            S_BR: begin
                done = 1'b1;
                if (br_taken) begin
                    alu_f      = ALU_ADD;
                    a_idx      = PC_IDX;
                    d_idx      = PC_IDX;
                    t16        = instr_q.imm;
                    carry_mask = 1'b1;
                    wr_reg     = 1'b1;
                    wr_flags   = instr_q.setf;
                end
            end
            S_ERR: begin
                err  = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            mem_addr_q <= 16'd0;
            rdata_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: every instruction class, memory waits,
// watchdog abort and asynchronous reset, with hand-computed expectations.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op_class;
    logic [3:0]  op_alu;
    logic [2:0]  op_ra, op_rb, op_rd;
    logic [15:0] op_imm;
    logic        op_setf, op_cmask;
    logic [1:0]  op_cbit;
    logic        op_cpol;
    logic [15:0] alu_flags, alu_mar;
    logic [3:0]  alu_f;
    logic [2:0]  a_idx, b_idx, d_idx;
    logic        wr_reg, wr_flags, sel_inp, carry_mask;
    logic [15:0] t16;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        done, err;
    logic [3:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_ctrl #(
        .SCRATCH_IDX(3'd7),
        .WAIT_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op_class    (op_class),
        .op_alu      (op_alu),
        .op_ra       (op_ra),
        .op_rb       (op_rb),
        .op_rd       (op_rd),
        .op_imm      (op_imm),
        .op_setf     (op_setf),
        .op_cmask    (op_cmask),
        .op_cbit     (op_cbit),
        .op_cpol     (op_cpol),
        .alu_flags   (alu_flags),
        .alu_mar     (alu_mar),
        .alu_f       (alu_f),
        .a_idx       (a_idx),
        .b_idx       (b_idx),
        .d_idx       (d_idx),
        .wr_reg      (wr_reg),
        .wr_flags    (wr_flags),
        .sel_inp     (sel_inp),
        .carry_mask  (carry_mask),
        .t16         (t16),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ctl(input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] d, input logic wr, input logic wf,
                                       input logic sel, input logic cm);
        return {f, a, b, d, wr, wf, sel, cm};
    endfunction

    // Compare all control outputs for the current cycle.
    task automatic expect_cyc(input string tag, input logic [16:0] e_ctl, input logic [15:0] e_t16,
                              input logic [1:0] e_mem, input logic [1:0] e_done_err, input logic e_rdy);
        check({tag, ".ctl"}, {alu_f, a_idx, b_idx, d_idx, wr_reg, wr_flags, sel_inp, carry_mask}, e_ctl);
        check({tag, ".t16"}, t16, e_t16);
        check({tag, ".req_we"}, {mem_req, mem_we}, e_mem);
        check({tag, ".done_err"}, {done, err}, e_done_err);
        check({tag, ".ready"}, instr_ready, e_rdy);
    endtask

    task automatic expect_idle(input string tag);
        expect_cyc(tag, 17'd0, 16'h0000, 2'b00, 2'b00, 1'b1);
    endtask

    // Move to the next cycle; inputs may then be changed, outputs sampled after #1.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction in IDLE, complete the handshake, then scramble the op fields.
    task automatic issue(input string tag, input logic [2:0] cls, input logic [3:0] alu,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                         input logic [15:0] imm, input logic setf, input logic cmask,
                         input logic [1:0] cbit, input logic cpol);
        op_class    = cls;
        op_alu      = alu;
        op_ra       = ra;
        op_rb       = rb;
        op_rd       = rd;
        op_imm      = imm;
        op_setf     = setf;
        op_cmask    = cmask;
        op_cbit     = cbit;
        op_cpol     = cpol;
        instr_valid = 1'b1;
        #1;
        check({tag, ".accept_ready"}, instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        op_class    = 3'd6;
        op_alu      = 4'hA;
        op_ra       = 3'd5;
        op_rb       = 3'd6;
        op_rd       = 3'd4;
        op_imm      = 16'h5A5A;
        op_setf     = ~setf;
        op_cmask    = ~cmask;
        op_cbit     = ~cbit;
        op_cpol     = ~cpol;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        op_class    = 3'd0;
        op_alu      = 4'd0;
        op_ra       = 3'd0;
        op_rb       = 3'd0;
        op_rd       = 3'd0;
        op_imm      = 16'h0000;
        op_setf     = 1'b0;
        op_cmask    = 1'b0;
        op_cbit     = 2'd0;
        op_cpol     = 1'b0;
        alu_flags   = 16'h0000;
        alu_mar     = 16'h0000;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        expect_idle("reset");
        check("reset.mem_addr", mem_addr, 16'h0000);
        check("reset.state", dbg_state, 4'd0);
        rst_n = 1'b1;
        tick();

        // RR ADD r1,r4 -> r2
        issue("rr", 3'd0, 4'd0, 3'd1, 3'd4, 3'd2, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0);
        #1; expect_cyc("rr.exec", ctl(4'd0, 3'd1, 3'd4, 3'd2, 1, 1, 1, 0), 16'h0000, 2'b00, 2'b10, 1'b0);
        tick(); #1; expect_idle("rr.after");

        // RI SUB r3,#0x1234 -> r5, no flag write, carry mask passed through
        issue("ri", 3'd1, 4'd2, 3'd3, 3'd0, 3'd5, 16'h1234, 1'b0, 1'b1, 2'd0, 1'b0);
        #1; expect_cyc("ri.exec", ctl(4'd2, 3'd3, 3'd0, 3'd5, 1, 0, 0, 1), 16'h1234, 2'b00, 2'b10, 1'b0);
        tick(); #1; expect_idle("ri.after");

        // LOAD r6 <- [r1+0x10], r1=0x1000, three wait cycles then ack with 0xBEEF
        issue("load", 3'd2, 4'd0, 3'd1, 3'd0, 3'd6, 16'h0010, 1'b1, 1'b0, 2'd0, 1'b0);
        alu_mar = 16'h1010;
        #1; expect_cyc("load.addr", ctl(4'd0, 3'd1, 3'd0, 3'd0, 0, 0, 0, 0), 16'h0010, 2'b00, 2'b00, 1'b0);
        for (int w = 0; w < 3; w++) begin
            tick();
            alu_mar = 16'hDEAD;
            #1; expect_cyc("load.wait", 17'd0, 16'h0000, 2'b10, 2'b00, 1'b0);
            check("load.mem_addr", mem_addr, 16'h1010);
        end
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        #1; expect_cyc("load.ack", 17'd0, 16'h0000, 2'b10, 2'b00, 1'b0);
        tick();
        mem_rdata = 16'h0000;
        #1; expect_cyc("load.clr", ctl(4'd15, 3'd0, 3'd0, 3'd6, 1, 0, 0, 0), 16'h0000, 2'b00, 2'b00, 1'b0);
        tick();
        mem_ack = 1'b0;
        #1; expect_cyc("load.merge", ctl(4'd5, 3'd6, 3'd0, 3'd6, 1, 1, 0, 0), 16'hBEEF, 2'b00, 2'b10, 1'b0);
        tick(); #1; expect_idle("load.after");

        // STORE [r2+0xFFF0] <- r5, address wraps to 0x0008, ack in first wait cycle
        issue("store", 3'd3, 4'd0, 3'd2, 3'd5, 3'd0, 16'hFFF0, 1'b0, 1'b0, 2'd0, 1'b0);
        alu_mar = 16'h0008;
        #1; expect_cyc("store.addr", ctl(4'd0, 3'd2, 3'd0, 3'd0, 0, 0, 0, 0), 16'hFFF0, 2'b00, 2'b00, 1'b0);
        tick();
        mem_ack = 1'b1;
        #1; expect_cyc("store.wait", ctl(4'd0, 3'd0, 3'd5, 3'd0, 0, 0, 0, 0), 16'h0000, 2'b11, 2'b10, 1'b0);
        check("store.mem_addr", mem_addr, 16'h0008);
        tick();
        #1; expect_idle("store.ack_ignored");
        mem_ack = 1'b0;

        // RMW INC [0x20], read 0xFFFF, one wait cycle on the write
        issue("rmw", 3'd4, 4'd7, 3'd0, 3'd3, 3'd1, 16'h0020, 1'b1, 1'b0, 2'd0, 1'b0);
        alu_mar = 16'h0020;
        #1; expect_cyc("rmw.addr", 17'd0, 16'h0020, 2'b00, 2'b00, 1'b0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        #1; expect_cyc("rmw.rwait", 17'd0, 16'h0000, 2'b10, 2'b00, 1'b0);
        tick();
        mem_ack = 1'b0;
        #1; expect_cyc("rmw.sclr", ctl(4'd15, 3'd0, 3'd0, 3'd7, 1, 0, 0, 0), 16'h0000, 2'b00, 2'b00, 1'b0);
        tick(); #1; expect_cyc("rmw.smerge", ctl(4'd5, 3'd7, 3'd0, 3'd7, 1, 0, 0, 0), 16'hFFFF, 2'b00, 2'b00, 1'b0);
        tick(); #1; expect_cyc("rmw.rop", ctl(4'd7, 3'd7, 3'd7, 3'd7, 1, 1, 1, 0), 16'h0000, 2'b00, 2'b00, 1'b0);
        tick(); #1; expect_cyc("rmw.wwait0", ctl(4'd0, 3'd0, 3'd7, 3'd0, 0, 0, 0, 0), 16'h0000, 2'b11, 2'b00, 1'b0);
        tick();
        mem_ack = 1'b1;
        #1; expect_cyc("rmw.wwait1", ctl(4'd0, 3'd0, 3'd7, 3'd0, 0, 0, 0, 0), 16'h0000, 2'b11, 2'b10, 1'b0);
        check("rmw.mem_addr", mem_addr, 16'h0020);
        tick();
        mem_ack = 1'b0;
        #1; expect_idle("rmw.after");

        // BRANCH on Z==1, Z set: PC += 0x0040
        issue("br_z1", 3'd5, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0040, 1'b0, 1'b0, 2'd2, 1'b1);
        alu_flags = 16'h0004;
        #1; expect_cyc("br_z1.exec", ctl(4'd0, 3'd3, 3'd0, 3'd3, 1, 0, 0, 1), 16'h0040, 2'b00, 2'b10, 1'b0);
        tick(); #1; expect_idle("br_z1.after");

        // BRANCH on Z==1, Z clear (other flags set): not taken, done still pulses
        issue("br_z0", 3'd5, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0040, 1'b0, 1'b0, 2'd2, 1'b1);
        alu_flags = 16'hFFFB;
        #1; expect_cyc("br_z0.exec", 17'd0, 16'h0000, 2'b00, 2'b10, 1'b0);
        tick(); #1; expect_idle("br_z0.after");

        // BRANCH on C==0, C clear with everything else set: taken, flags written
        issue("br_c0", 3'd5, 4'd0, 3'd0, 3'd0, 3'd0, 16'hFFFE, 1'b1, 1'b0, 2'd0, 1'b0);
        alu_flags = 16'hFFFE;
        #1; expect_cyc("br_c0.exec", ctl(4'd0, 3'd3, 3'd0, 3'd3, 1, 1, 0, 1), 16'hFFFE, 2'b00, 2'b10, 1'b0);
        tick(); #1; expect_idle("br_c0.after");
        alu_flags = 16'h0000;

        // Illegal classes 6 and 7
        issue("ill6", 3'd6, 4'd0, 3'd1, 3'd1, 3'd1, 16'h1111, 1'b1, 1'b1, 2'd0, 1'b0);
        #1; expect_cyc("ill6.err", 17'd0, 16'h0000, 2'b00, 2'b11, 1'b0);
        tick(); #1; expect_idle("ill6.after");
        issue("ill7", 3'd7, 4'd0, 3'd1, 3'd1, 3'd1, 16'h1111, 1'b1, 1'b1, 2'd0, 1'b0);
        #1; expect_cyc("ill7.err", 17'd0, 16'h0000, 2'b00, 2'b11, 1'b0);
        tick(); #1; expect_idle("ill7.after");

        // Watchdog: LOAD never acked, limit 4 -> abort after four wait cycles
        issue("wdog", 3'd2, 4'd0, 3'd2, 3'd0, 3'd3, 16'h0004, 1'b1, 1'b0, 2'd0, 1'b0);
        alu_mar = 16'h2004;
        #1; expect_cyc("wdog.addr", ctl(4'd0, 3'd2, 3'd0, 3'd0, 0, 0, 0, 0), 16'h0004, 2'b00, 2'b00, 1'b0);
        for (int w = 0; w < 4; w++) begin
            tick(); #1; expect_cyc("wdog.wait", 17'd0, 16'h0000, 2'b10, 2'b00, 1'b0);
        end
        tick(); #1; expect_cyc("wdog.abort", 17'd0, 16'h0000, 2'b00, 2'b01, 1'b0);
        tick();
        mem_ack = 1'b1;
        #1; expect_idle("wdog.after");
        mem_ack = 1'b0;

        // Watchdog on the write leg of a STORE
        issue("wdogw", 3'd3, 4'd0, 3'd0, 3'd4, 3'd0, 16'h0100, 1'b0, 1'b0, 2'd0, 1'b0);
        alu_mar = 16'h0100;
        #1;
        for (int w = 0; w < 4; w++) begin
            tick(); #1; expect_cyc("wdogw.wait", ctl(4'd0, 3'd0, 3'd4, 3'd0, 0, 0, 0, 0), 16'h0000, 2'b11, 2'b00, 1'b0);
        end
        tick(); #1;
        check("wdogw.abort_req", {mem_req, mem_we}, 2'b00);
        check("wdogw.abort_de", {done, err}, 2'b01);
        tick(); #1; expect_idle("wdogw.after");

        // Asynchronous reset in RWAIT
        issue("arst", 3'd2, 4'd0, 3'd1, 3'd0, 3'd6, 16'h0010, 1'b0, 1'b0, 2'd0, 1'b0);
        alu_mar = 16'h3000;
        tick(); #1;
        check("arst.req_before", mem_req, 1'b1);
        #1; rst_n = 1'b0;
        #1;
        check("arst.req", mem_req, 1'b0);
        check("arst.ready", instr_ready, 1'b1);
        check("arst.state", dbg_state, 4'd0);
        check("arst.mem_addr", mem_addr, 16'h0000);
        rst_n = 1'b1;
        tick(); #1; expect_idle("arst.after");

        // Normal operation after reset
        issue("rr2", 3'd0, 4'd6, 3'd7, 3'd6, 3'd5, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0);
        #1; expect_cyc("rr2.exec", ctl(4'd6, 3'd7, 3'd6, 3'd5, 1, 0, 1, 0), 16'h0000, 2'b00, 2'b10, 1'b0);
        tick(); #1; expect_idle("rr2.after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
